// File: rtl/pipe_pkg.sv
// Shared defaults and skid-buffer state encoding for the pipeline stage.
package pipe_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int NUM_FIELDS_DEF = 3;
    localparam int RST_VAL_DEF    = 0;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_MAIN  = 2'd1,
        SKID_BOTH  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_slot.sv
// Payload register with load enable and synchronous clear to a fixed word.
module pipe_slot #(
    parameter int          W        = 96,
    parameter logic [W-1:0] RST_WORD = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Clear wins over load so a kill in the same cycle drops the payload.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = RST_WORD;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= RST_WORD;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid slot that registers in_ready.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                NUM_FIELDS = NUM_FIELDS_DEF,
    parameter logic [DATA_W-1:0] RST_VAL    = DATA_W'(RST_VAL_DEF)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    input  logic                         flush,
    output logic [15:0]                  stall_cnt
);

    localparam int           W        = NUM_FIELDS * DATA_W;
    localparam logic [W-1:0] RST_WORD = {NUM_FIELDS{RST_VAL}};

    logic         in_fire;
    logic         out_fire;
    logic         main_en;
    logic [W-1:0] main_d_in;
    logic [15:0]  stall_cnt_q;
    logic [15:0]  stall_cnt_d;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    skid_state_e  state_q;
    skid_state_e  state_d;
    logic         skid_en;
    logic [W-1:0] skid_q;

    assign out_valid = (state_q != SKID_EMPTY);
    // Only flush reaches in_ready combinationally; out_ready never does.
    assign in_ready  = (state_q != SKID_BOTH) | flush;

    always_comb begin
        state_d   = state_q;
        main_en   = 1'b0;
        main_d_in = in_data;
        skid_en   = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (in_fire) begin
                    main_en = 1'b1;
                    state_d = SKID_MAIN;
                end
            end
            SKID_MAIN: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    skid_en = 1'b1;
                    state_d = SKID_BOTH;
                end else if (out_fire) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_BOTH: begin
                if (out_fire) begin
                    main_en   = 1'b1;
                    main_d_in = skid_q;
                    state_d   = SKID_MAIN;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        if (flush) begin
            state_d = SKID_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_slot #(
        .W        (W),
        .RST_WORD (RST_WORD)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );
`else
    logic out_valid_q;
    logic out_valid_d;

    assign out_valid = out_valid_q;
    assign in_ready  = ~out_valid_q | out_ready | flush;

    always_comb begin
        main_en     = in_fire;
        main_d_in   = in_data;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end
`endif

    pipe_slot #(
        .W        (W),
        .RST_WORD (RST_WORD)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (main_en),
        .d     (main_d_in),
        .q     (out_data)
    );

    // Counts back-pressured cycles; flush does not touch it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: queue-based reference model plus directed scenarios.
module tb_pipe_stage;

    localparam int DW = 32;
    localparam int NF = 3;
    localparam int W  = DW * NF;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          flush;
    logic [15:0]   stall_cnt;

    int n_err    = 0;
    int n_checks = 0;

    pipe_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [31:0] v);
        return {v + 32'h200, v + 32'h100, v};
    endfunction

    // Reference model: the stage is a FIFO of capacity CAP whose head is out_data.
    logic [W-1:0] mq[$];
    logic [W-1:0] shown;
    int unsigned  mcnt;
    bit           check_en   = 0;
    bit           collect_en = 0;
    logic [31:0]  rx[$];

    function automatic bit model_ready();
        if (flush) return 1'b1;
        if (CAP == 2) return (mq.size() < 2);
        return (mq.size() == 0) || out_ready;
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            mq.delete();
            shown = '0;
            mcnt  = 0;
        end else begin
            if (mq.size() > 0 && !out_ready && mcnt < 32'hFFFF) mcnt++;
            if (flush) begin
                mq.delete();
                shown = '0;
            end else begin
                acc = in_valid && model_ready();
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
                if (mq.size() > 0) shown = mq[0];
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_out_valid", W'(out_valid), W'(mq.size() > 0));
            chk("cyc_out_data", out_data, shown);
            chk("cyc_in_ready", W'(in_ready), W'(model_ready()));
            chk("cyc_stall_cnt", W'(stall_cnt), W'(mcnt));
            if (collect_en && out_valid && out_ready) rx.push_back(out_data[31:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        int c;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        step();
        check_en = 1;
        step();
        #2;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_stall", W'(stall_cnt), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));

        // First payload after reset, one-cycle latency
        step();
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = {32'h8, 32'h4, 32'h2400_0001};
        out_ready = 1'b1;
        #2;
        chk("first_in_ready", W'(in_ready), W'(1));
        step();
        in_valid = 1'b0;
        #2;
        chk("first_out_valid", W'(out_valid), W'(1));
        chk("first_out_data", out_data, 96'h00000008_00000004_24000001);
        chk("first_in_ready2", W'(in_ready), W'(1));
        step();

        // Stream 1..8 with back-pressure on cycles 3-5
        collect_en = 1;
        idx = 1;
        c   = 1;
        while (rx.size() < 8 && c <= 40) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (idx <= 8);
            in_data   = mk(idx);
            #2;
            if (in_valid && in_ready) idx++;
            step();
            c++;
        end
        collect_en = 0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        chk("stream_count", W'(rx.size()), W'(8));
        for (int i = 0; i < 8 && i < rx.size(); i++) chk("stream_order", W'(rx[i]), W'(i + 1));
        chk("stream_stall", W'(stall_cnt), W'(3));
        step();
        step();

        // Flush while stalled drops both held and incoming payload
        in_valid  = 1'b1;
        in_data   = mk(32'hAA);
        out_ready = 1'b0;
        step();
        flush    = 1'b1;
        in_data  = mk(32'hBB);
        #2;
        chk("flush_in_ready", W'(in_ready), W'(1));
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("flush_out_valid", W'(out_valid), W'(0));
        chk("flush_out_data", out_data, '0);
        out_ready = 1'b1;
        repeat (3) step();

`ifdef PIPE_STAGE_SKID_EN
        // Fill the skid slot, then drain in order
        in_valid = 1'b1;
        in_data  = mk(32'h11);
        step();
        out_ready = 1'b0;
        in_data   = mk(32'h22);
        step();
        in_valid = 1'b0;
        #2;
        chk("skid_in_ready_both", W'(in_ready), W'(0));
        chk("skid_head", W'(out_data[31:0]), W'(32'h11));
        out_ready = 1'b1;
        step();
        #2;
        chk("skid_second", W'(out_data[31:0]), W'(32'h22));
        chk("skid_second_valid", W'(out_valid), W'(1));
        chk("skid_in_ready_main", W'(in_ready), W'(1));
        step();
        step();
`endif

        // Stall counter saturation
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = mk(32'h33);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (70000) step();
        #2;
        chk("sat_stall", W'(stall_cnt), W'(16'hFFFF));
        repeat (5) step();
        #2;
        chk("sat_hold", W'(stall_cnt), W'(16'hFFFF));

        // Reset while full with stall_cnt=5
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = mk(32'h44);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_data   = mk(32'h55);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        #2;
        chk("pre_rst_stall", W'(stall_cnt), W'(5));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #2;
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_stall", W'(stall_cnt), W'(0));
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
